// File: rtl/button_conditioner.sv
// button_conditioner
// Synchronizes and debounces the nine active-low cell buttons, then turns each
// accepted press into a one-cycle active-low strobe, issued one at a time
// (lowest channel first) and only while the display is in blanking.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [8:0] btn_n_raw,
  input  logic       vnotactive,
  output logic       board_but00,
  output logic       board_but01,
  output logic       board_but02,
  output logic       board_but10,
  output logic       board_but11,
  output logic       board_but12,
  output logic       board_but20,
  output logic       board_but21,
  output logic       board_but22,
  output logic [8:0] btn_level_n,
  output logic       busy
);

  // Counter value on which the DEBOUNCE_CYCLES-th differing sample lands.
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [8:0]       r_sync1;
  logic [8:0]       r_sync2;
  logic [8:0]       r_levelN;
  logic [CNT_W-1:0] r_cnt [9];
  logic [8:0]       r_pending;
  logic             r_busy;
  logic [8:0]       r_strobeN;

  logic [8:0]       w_accept;
  logic [8:0]       w_press;
  logic [8:0]       w_lowest;
  logic [8:0]       w_clear;
  logic [8:0]       w_pendingNext;

  // Two-flop synchronizer; idle (released) buttons read as 1.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= btn_n_raw;
      r_sync2 <= r_sync1;
    end
  end

  // A channel accepts its new level on the final differing sample; a press is
  // an accepted change towards 0.
  always_comb begin
    w_accept = '0;
    w_press  = '0;
    for (int i = 0; i < 9; i++) begin
      w_accept[i] = (r_sync2[i] != r_levelN[i]) && (r_cnt[i] == LAST_COUNT);
      w_press[i]  = w_accept[i] && !r_sync2[i];
    end
  end

  // Per-channel debounce counters and debounced levels; any matching sample
  // restarts the count.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_levelN <= '1;
      for (int i = 0; i < 9; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 9; i++) begin
        if (r_sync2[i] == r_levelN[i]) begin
          r_cnt[i] <= '0;
        end else if (w_accept[i]) begin
          r_levelN[i] <= r_sync2[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Pick the lowest pending channel during blanking; a new press on the same
  // channel overrides its clear so the second press is not lost.
  always_comb begin
    w_lowest      = r_pending & (~r_pending + 9'd1);
    w_clear       = vnotactive ? w_lowest : 9'd0;
    w_pendingNext = (r_pending & ~w_clear) | w_press;
  end

  // Pending set, busy flag and the registered strobes all move on one edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_pending <= '0;
      r_busy    <= 1'b0;
      r_strobeN <= '1;
    end else begin
      r_pending <= w_pendingNext;
      r_busy    <= |w_pendingNext;
      r_strobeN <= ~w_clear;
    end
  end

  assign btn_level_n = r_levelN;
  assign busy        = r_busy;
  assign board_but00 = r_strobeN[0];
  assign board_but01 = r_strobeN[1];
  assign board_but02 = r_strobeN[2];
  assign board_but10 = r_strobeN[3];
  assign board_but11 = r_strobeN[4];
  assign board_but12 = r_strobeN[5];
  assign board_but20 = r_strobeN[6];
  assign board_but21 = r_strobeN[7];
  assign board_but22 = r_strobeN[8];

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner with a short debounce window.
// A sample-history reference model is compared on every cycle, and the
// directed scenarios pin the model with hand-computed cycle expectations.
module tb_button_conditioner;

  localparam int D = 4;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [8:0] btn_n_raw = 9'h1FF;
  logic       vnotactive = 1'b1;
  logic       board_but00, board_but01, board_but02;
  logic       board_but10, board_but11, board_but12;
  logic       board_but20, board_but21, board_but22;
  logic [8:0] btn_level_n;
  logic       busy;
  logic [8:0] dutStrobe;

  int nChecks = 0;
  int nFails  = 0;
  int strobeCnt [9];

  // Reference model state
  logic [8:0]   mS1, mS2, mLevel, mPending, expStrobe, mPress;
  logic         mBusy;
  logic [D-1:0] mHist [9];
  int           pick;

  button_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .CLK(CLK), .RST(RST), .btn_n_raw(btn_n_raw), .vnotactive(vnotactive),
    .board_but00(board_but00), .board_but01(board_but01), .board_but02(board_but02),
    .board_but10(board_but10), .board_but11(board_but11), .board_but12(board_but12),
    .board_but20(board_but20), .board_but21(board_but21), .board_but22(board_but22),
    .btn_level_n(btn_level_n), .busy(busy)
  );

  assign dutStrobe = {board_but22, board_but21, board_but20, board_but12, board_but11,
                      board_but10, board_but02, board_but01, board_but00};

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input int actual, input int expected);
    nChecks++;
    if (actual != expected) begin
      nFails++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [8:0] raw, input logic vn, input logic rst);
    @(negedge CLK);
    #1;
    btn_n_raw  = raw;
    vnotactive = vn;
    RST        = rst;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(btn_n_raw, vnotactive, 1'b1);
  endtask

  // Reference model: a level flips once the last D synchronized samples all
  // disagree with it; pending presses are served lowest index first.
  initial begin
    forever begin
      @(posedge CLK or negedge RST);
      if (!RST) begin
        mS1 = '1; mS2 = '1; mLevel = '1; mPending = '0; mBusy = 1'b0; expStrobe = '1;
        for (int i = 0; i < 9; i++) mHist[i] = '1;
      end else begin
        mPress = '0;
        for (int i = 0; i < 9; i++) begin
          mHist[i] = {mHist[i][D-2:0], mS2[i]};
          if (mHist[i] == {D{~mLevel[i]}}) begin
            mLevel[i] = ~mLevel[i];
            if (!mLevel[i]) mPress[i] = 1'b1;
          end
        end
        pick = -1;
        if (vnotactive) begin
          for (int i = 8; i >= 0; i--) if (mPending[i]) pick = i;
        end
        expStrobe = '1;
        if (pick >= 0) begin
          expStrobe[pick] = 1'b0;
          mPending[pick]  = 1'b0;
        end
        mPending = mPending | mPress;
        mBusy    = |mPending;
        mS2 = mS1;
        mS1 = btn_n_raw;
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge CLK) begin
    checkOutput("strobes", int'(dutStrobe), int'(expStrobe));
    checkOutput("level", int'(btn_level_n), int'(mLevel));
    checkOutput("busy", int'(busy), int'(mBusy));
    for (int i = 0; i < 9; i++) if (!dutStrobe[i]) strobeCnt[i]++;
    if (!$isunknown(dutStrobe) && ($countones(~dutStrobe) > 1)) checkOutput("one_strobe", 0, 1);
  end

  initial begin
    int c0, c3, c8;
    for (int i = 0; i < 9; i++) strobeCnt[i] = 0;

    // Reset with random buttons: outputs hold their idle values.
    for (int k = 0; k < 5; k++) begin
      applyStimulus(9'($urandom), 1'b1, 1'b0);
      @(posedge CLK); #1;
      checkOutput("rst_strobes", int'(dutStrobe), 'h1FF);
      checkOutput("rst_level", int'(btn_level_n), 'h1FF);
      checkOutput("rst_busy", int'(busy), 0);
    end
    applyStimulus(9'h1FF, 1'b1, 1'b1);
    idle(10);

    // Clean press on cell 11.
    applyStimulus(9'h1EF, 1'b1, 1'b1);
    for (int k = 1; k <= 10; k++) begin
      @(posedge CLK); #1;
      checkOutput("press_level", int'(btn_level_n), (k >= 6) ? 'h1EF : 'h1FF);
      checkOutput("press_strobe", int'(dutStrobe), (k == 7) ? 'h1EF : 'h1FF);
    end
    applyStimulus(9'h1FF, 1'b1, 1'b1);
    idle(10);

    // Bounce shorter than the window is rejected.
    c0 = strobeCnt[0];
    for (int k = 0; k < 3; k++) applyStimulus(9'h1FE, 1'b1, 1'b1);
    applyStimulus(9'h1FF, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) applyStimulus(9'h1FE, 1'b1, 1'b1);
    applyStimulus(9'h1FF, 1'b1, 1'b1);
    idle(10);
    checkOutput("bounce_strobes", strobeCnt[0] - c0, 0);
    checkOutput("bounce_level", int'(btn_level_n), 'h1FF);
    checkOutput("bounce_busy", int'(busy), 0);

    // Long hold yields exactly one strobe.
    c8 = strobeCnt[8];
    for (int k = 0; k < 1000; k++) applyStimulus(9'h0FF, 1'b1, 1'b1);
    applyStimulus(9'h1FF, 1'b1, 1'b1);
    idle(20);
    checkOutput("hold_strobes", strobeCnt[8] - c8, 1);
    checkOutput("hold_level", int'(btn_level_n), 'h1FF);

    // Three simultaneous presses served on consecutive cycles.
    applyStimulus(9'h0DE, 1'b1, 1'b1);
    for (int k = 1; k <= 10; k++) begin
      @(posedge CLK); #1;
      checkOutput("cont_strobe", int'(dutStrobe),
                  (k == 7) ? 'h1FE : (k == 8) ? 'h1DF : (k == 9) ? 'h0FF : 'h1FF);
      checkOutput("cont_busy", int'(busy), (k >= 6 && k <= 8) ? 1 : 0);
    end
    applyStimulus(9'h1FF, 1'b1, 1'b1);
    idle(10);

    // Deferral while the frame is visible.
    c3 = strobeCnt[3];
    applyStimulus(9'h1F7, 1'b0, 1'b1);
    idle(60);
    checkOutput("defer_busy", int'(busy), 1);
    checkOutput("defer_strobes", strobeCnt[3] - c3, 0);
    applyStimulus(9'h1F7, 1'b1, 1'b1);
    @(posedge CLK); #1;
    checkOutput("defer_release", int'(dutStrobe), 'h1F7);
    @(posedge CLK); #1;
    checkOutput("defer_after", int'(dutStrobe), 'h1FF);
    checkOutput("defer_busy_clr", int'(busy), 0);
    applyStimulus(9'h1FF, 1'b1, 1'b1);
    idle(10);

    // Pending press discarded by a reset pulse.
    c3 = strobeCnt[3];
    applyStimulus(9'h1F7, 1'b0, 1'b1);
    idle(20);
    applyStimulus(9'h1FF, 1'b0, 1'b1);
    idle(10);
    checkOutput("rstp_busy_pre", int'(busy), 1);
    applyStimulus(9'h1FF, 1'b0, 1'b0);
    applyStimulus(9'h1FF, 1'b1, 1'b1);
    idle(10);
    checkOutput("rstp_busy", int'(busy), 0);
    checkOutput("rstp_strobes", strobeCnt[3] - c3, 0);

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 4000; k++) begin
      logic [8:0] raw;
      raw = btn_n_raw;
      for (int i = 0; i < 9; i++) if ($urandom_range(0, 15) == 0) raw[i] = ~raw[i];
      applyStimulus(raw, ($urandom_range(0, 3) != 0), ($urandom_range(0, 499) != 0));
    end
    applyStimulus(9'h1FF, 1'b1, 1'b1);
    idle(30);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
